// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the 8-bit combinational ALU: local register file,
// one instruction in flight, valid/ready on both the instruction and result sides.
module alu_op_sequencer #(
    parameter  int WIDTH    = 8,
    parameter  int RF_DEPTH = 4,
    localparam int IDX_W    = $clog2(RF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IDX_W-1:0] in_rd,
    input  logic [IDX_W-1:0] in_ra,
    input  logic [IDX_W-1:0] in_rb,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [IDX_W-1:0] res_rd,
    output logic             res_zero,
    input  logic [IDX_W-1:0] dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    // state    | meaning
    // ST_IDLE  | waiting for an instruction, in_ready high
    // ST_ISSUE | operands on the ALU, result captured at the closing edge
    // ST_RESP  | result held on res_* until res_ready
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [2:0] OP_LOADI = 3'b111;

    logic [1:0]       state;
    logic [WIDTH-1:0] rf [RF_DEPTH];
    logic [IDX_W-1:0] rd_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] cap_val;

    // LOADI bypasses the ALU, which returns zero for that code
    assign cap_val  = (alu_op == OP_LOADI) ? imm_q : alu_out;
    assign in_ready = (state == ST_IDLE);
    assign dbg_data = rf[dbg_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_a  <= rf[in_ra];
                        alu_b  <= rf[in_rb];
                        alu_op <= in_op;
                        rd_q   <= in_rd;
                        imm_q  <= in_imm;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rf[rd_q]  <= cap_val;
                    res_data  <= cap_val;
                    res_rd    <= rd_q;
                    res_zero  <= (cap_val == '0);
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed program plus randomized
// instructions against a register-file reference model and a behavioural ALU.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [1:0] in_rd = '0, in_ra = '0, in_rb = '0;
    logic [7:0] in_imm = '0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [1:0] res_rd;
    logic       res_zero;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] ref_rf [4];

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8), .RF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_zero(res_zero),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return 8'(a[3:0]) * 8'(b[3:0]);
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    // external ALU the sequencer drives
    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rf();
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("dbg_rf%0d", i), 32'(dbg_data), 32'(ref_rf[i]));
        end
    endtask

    // one full instruction; stall = cycles res_ready stays low once res_valid is up,
    // lit >= 0 adds a check against a hand-computed result
    task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                            input logic [1:0] rb, input logic [7:0] imm, input int stall,
                            input int lit);
        logic [7:0] a, b, v;
        a = ref_rf[ra];
        b = ref_rf[rb];
        v = (op == 3'b111) ? imm : alu_fn(a, b, op);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
        res_ready = (stall == 0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_ra = 2'($urandom); in_rb = 2'($urandom); in_imm = 8'($urandom);
        check("issue_alu_a", 32'(alu_a), 32'(a));
        check("issue_alu_b", 32'(alu_b), 32'(b));
        check("issue_alu_op", 32'(alu_op), 32'(op));
        check("issue_in_ready", 32'(in_ready), 32'd0);
        check("issue_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("resp_valid", 32'(res_valid), 32'd1);
        check("resp_data", 32'(res_data), 32'(v));
        check("resp_rd", 32'(res_rd), 32'(rd));
        check("resp_zero", 32'(res_zero), 32'(v == 8'h00));
        if (lit >= 0) check("resp_literal", 32'(res_data), 32'(lit));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_data", 32'(res_data), 32'(v));
            check("stall_rd", 32'(res_rd), 32'(rd));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        if (stall > 0) begin
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        check("done_valid", 32'(res_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("hold_alu_op", 32'(alu_op), 32'(op));
        ref_rf[rd] = v;
        check_rf();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu", {8'h00, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
        check("rst_res", {21'h0, res_data, res_rd, res_zero}, 32'd0);
        check_rf();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        do_instr(3'b111, 2'd1, 2'd0, 2'd0, 8'h3C, 0, 'h3C);
        do_instr(3'b111, 2'd2, 2'd0, 2'd0, 8'h0F, 0, 'h0F);
        do_instr(3'b101, 2'd3, 2'd1, 2'd2, 8'h00, 0, 'h4B);
        do_instr(3'b110, 2'd0, 2'd2, 2'd1, 8'h00, 0, 'hD3);
        do_instr(3'b100, 2'd0, 2'd1, 2'd2, 8'h00, 0, 'hB4);
        do_instr(3'b000, 2'd0, 2'd1, 2'd0, 8'h00, 0, 'hC3);
        do_instr(3'b010, 2'd1, 2'd1, 2'd1, 8'h00, 0, 'h00);
        do_instr(3'b011, 2'd2, 2'd1, 2'd2, 8'h00, 5, 'h00);

        // reset landing mid-ISSUE abandons the ADD
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b101; in_rd = 2'd3; in_ra = 2'd3; in_rb = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_issue_op", 32'(alu_op), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_alu", {8'h00, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
        check("arst_res", {21'h0, res_data, res_rd, res_zero}, 32'd0);
        check_rf();
        repeat (3) begin
            @(posedge clk); #1;
            check("arst_no_valid", 32'(res_valid), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
        do_instr(3'b111, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 'hFF);

        for (int n = 0; n < 60; n++) begin
            do_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                     8'($urandom), int'($urandom_range(0, 3)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator/controller for the team's 8-bit combinational ALU (ports A, B, OP, OUT).
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from a small local register file, drives them to an external ALU instance, captures the ALU result into the destination register, and returns the result over a second valid/ready handshake.
- Sits between an instruction source (testbench, host FSM) and the ALU.

Parameters:
WIDTH, 8, datapath width; must match the ALU (8).
RF_DEPTH, 4, number of registers; index width is 2 bits; fixed power of two.

Ports:
CLK  in  1  clock, rising-edge.
RST_N  in  1  asynchronous, active-low reset.
IN_VALID  in  1  instruction valid.
IN_READY  out  1  sequencer can accept an instruction.
IN_OP  in  3  operation code.
IN_RD  in  2  destination register index.
IN_RA  in  2  source A register index.
IN_RB  in  2  source B register index.
IN_IMM  in  8  immediate value, used only by LOADI.
ALU_A  out  8  operand A to ALU port A.
ALU_B  out  8  operand B to ALU port B.
ALU_OP  out  3  opcode to ALU port OP.
ALU_OUT  in  8  ALU result from ALU port OUT (combinational).
RES_VALID  out  1  result valid.
RES_READY  in  1  result consumer ready.
RES_DATA  out  8  value written to RF[RES_RD].
RES_RD  out  2  destination index of the result.
RES_ZERO  out  1  RES_DATA == 0.
DBG_SEL  in  2  debug read index.
DBG_DATA  out  8  combinational RF[DBG_SEL].

Behaviour:
- Reset is asynchronous and active-low.
- RST_N low forces, immediately:
  - state to IDLE
  - all RF entries to 0x00
  - ALU_A, ALU_B, ALU_OP, RES_DATA, RES_RD, RES_ZERO to 0
  - RES_VALID to 0
- IN_READY = (state == IDLE), combinational; it reads 1 while in reset.
- Opcode encoding, same as the ALU:
  - 000 NOT A; 001 A|B; 010 A^B; 011 A&B
  - 100 A[3:0]*B[3:0] (8-bit product); 101 A+B mod 256; 110 A-B mod 256 (two's complement wrap)
  - 111 is LOADI, handled locally; the ALU returns 0 for this code.
- FSM states IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - On IN_VALID & IN_READY at a rising edge, register ALU_A <= RF[IN_RA], ALU_B <= RF[IN_RB], ALU_OP <= IN_OP.
  - Latch IN_RD and IN_IMM, then go to ISSUE.
  - IN_VALID low: stay in IDLE; ALU_* hold their last values.
- ISSUE (exactly 1 cycle):
  - ALU_A/B/OP are stable for the whole cycle.
  - At the rising edge ending ISSUE, capture V = (op==111) ? IMM : ALU_OUT.
  - Write RF[RD] <= V; set RES_DATA <= V, RES_RD <= RD, RES_ZERO <= (V==0), RES_VALID <= 1; go to RESP.
- RESP:
  - RES_VALID = 1; RES_DATA, RES_RD and RES_ZERO are held stable.
  - On RES_VALID & RES_READY at a rising edge, clear RES_VALID and go to IDLE.
  - RES_READY held high means RESP lasts 1 cycle.
- Latency and throughput:
  - Acceptance edge to RES_VALID high is 2 edges.
  - Minimum issue interval is 3 cycles.
  - IN_VALID is ignored outside IDLE; the source must hold the instruction until accepted.
- Hazards: the RF write completes before IDLE, so back-to-back dependent instructions read the updated value. RD == RA/RB within one instruction reads the old value.
- DBG_DATA:
  - Reflects an RF write on the cycle after the write edge.
  - Reads 0x00 during reset.
- Reset during ISSUE or RESP:
  - The instruction is abandoned and no RES_VALID is produced.
  - The RF write is lost if reset lands before the capturing edge.
  - After release, the block is in IDLE with IN_READY = 1.

Test Plan:
- Reset, then LOADI RD=1 IMM=0x3C, then LOADI RD=2 IMM=0x0F -> RES_DATA 0x3C/RES_RD 1, then 0x0F/RES_RD 2; DBG_SEL=1 gives 0x3C, DBG_SEL=2 gives 0x0F; RES_ZERO=0.
- ADD RD=3 RA=1 RB=2 -> during ISSUE ALU_A=0x3C, ALU_B=0x0F, ALU_OP=101; RES_VALID exactly 2 edges after acceptance; RES_DATA=0x4B; RF[3]=0x4B.
- SUB RD=0 RA=2 RB=1 -> 0xD3 (wrap). MUL RD=0 RA=1 RB=2 -> 0x0C*0x0F=0xB4. NOT RD=0 RA=1 -> 0xC3.
- XOR RD=1 RA=1 RB=1 -> RES_DATA=0x00, RES_ZERO=1, RF[1]=0x00. A following AND RD=2 RA=1 RB=2 -> 0x00, confirming the dependent read.
- RES_READY low for 5 cycles after RES_VALID -> RES_VALID/RES_DATA/RES_RD stable; IN_READY=0; a new IN_VALID pulse is not accepted. Raising RES_READY gives IDLE on the next edge, then acceptance.
- Assert RST_N low mid-ISSUE of ADD -> all outputs 0 asynchronously, RF all 0x00, no RES_VALID. After release, IN_READY=1 and LOADI RD=0 IMM=0xFF gives RES_DATA=0xFF.
